// File: rtl/wb_result_fifo.sv
// In-order result queue between multi-cycle producers and writeback.
// Registered outputs only; sticky overflow/underflow flags clear on flush or reset.
module wb_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic [WIDTH-1:0]           d,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           q,
   output logic                       q_valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       udf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             mem_we;
   logic             wr_ok, rd_ok;

   assign q_valid = (count_q != '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;
   assign q       = q_valid ? mem_q[rptr_q] : '0;

   // A write at full is still accepted when the same cycle frees the head slot.
   assign wr_ok = en && (!full || rd_en);
   assign rd_ok = rd_en && q_valid;

   // NOTE: every always_comb output gets a default first, so no path leaves a latch.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      mem_we  = 1'b0;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
            mem_we = 1'b1;
         end
         if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (en && !wr_ok) begin
            ovf_d = 1'b1;
         end
         if (rd_en && !q_valid) begin
            udf_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // NOTE: storage is deliberately reset so no stale word survives clr_n; flush leaves it untouched.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[wptr_q] <= d;
      end
   end

endmodule

// File: tb/tb_wb_result_fifo.sv
// Directed bench for wb_result_fifo: fill, drain, overflow, empty corner,
// wrap-around, flush and asynchronous reset mid-operation.
module tb_wb_result_fifo;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] d;
   logic        en;
   logic        flush;
   logic        rd_en;
   logic [31:0] q;
   logic        q_valid;
   logic        full;
   logic [2:0]  count;
   logic        ovf;
   logic        udf;

   int total = 0;
   int bad   = 0;

   wb_result_fifo #(.WIDTH(32), .DEPTH(4)) dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .d       (d),
      .en      (en),
      .flush   (flush),
      .rd_en   (rd_en),
      .q       (q),
      .q_valid (q_valid),
      .full    (full),
      .count   (count),
      .ovf     (ovf),
      .udf     (udf)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; rd_en = 1'b0; flush = 1'b0; d = '0;
   endtask

   task automatic push(input logic [31:0] v);
      en = 1'b1; rd_en = 1'b0; d = v;
      cyc();
      idle();
   endtask

   task automatic test_reset();
      idle();
      clr_n = 1'b0;
      cyc(); cyc();
      total++; if (q !== 32'h0)       begin bad++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
      total++; if (q_valid !== 1'b0)  begin bad++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
      total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (count !== 3'd0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (ovf !== 1'b0)      begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      total++; if (udf !== 1'b0)      begin bad++; $display("FAIL reset_udf got=%b exp=0", udf); end
      clr_n = 1'b1;
   endtask

   task automatic test_fill();
      logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; d = vals[i];
         cyc();
         total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
         total++; if (q !== 32'h11)        begin bad++; $display("FAIL fill_q[%0d] got=%h exp=11", i, q); end
      end
      idle();
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
   endtask

   task automatic drain_check(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         total++; if (q !== exp[i]) begin bad++; $display("FAIL %s_q[%0d] got=%h exp=%h", tag, i, q, exp[i]); end
         cyc();
      end
      idle();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL %s_q_valid got=%b exp=0", tag, q_valid); end
      total++; if (q !== 32'h0)      begin bad++; $display("FAIL %s_q_empty got=%h exp=0", tag, q); end
      total++; if (count !== 3'd0)   begin bad++; $display("FAIL %s_count got=%0d exp=0", tag, count); end
      total++; if (udf !== 1'b0)     begin bad++; $display("FAIL %s_udf got=%b exp=0", tag, udf); end
   endtask

   task automatic test_drain();
      drain_check("drain", 32'h11, 32'h22, 32'h33, 32'h44);
   endtask

   task automatic test_overflow();
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      en = 1'b1; rd_en = 1'b0; d = 32'h55;
      cyc();
      idle();
      total++; if (ovf !== 1'b1)    begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
      total++; if (count !== 3'd4)  begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
      total++; if (q !== 32'h11)    begin bad++; $display("FAIL ovf_q got=%h exp=11", q); end
      en = 1'b1; rd_en = 1'b1; d = 32'h66;
      total++; if (q !== 32'h11)    begin bad++; $display("FAIL simul_popped got=%h exp=11", q); end
      cyc();
      idle();
      total++; if (count !== 3'd4)  begin bad++; $display("FAIL simul_count got=%0d exp=4", count); end
      total++; if (full !== 1'b1)   begin bad++; $display("FAIL simul_full got=%b exp=1", full); end
      drain_check("tail", 32'h22, 32'h33, 32'h44, 32'h66);
      total++; if (ovf !== 1'b1)    begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
   endtask

   task automatic test_empty();
      rd_en = 1'b1;
      cyc();
      idle();
      total++; if (udf !== 1'b1)    begin bad++; $display("FAIL udf_set got=%b exp=1", udf); end
      total++; if (count !== 3'd0)  begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
      en = 1'b1; rd_en = 1'b1; d = 32'hA5A5A5A5;
      cyc();
      idle();
      total++; if (q !== 32'hA5A5A5A5) begin bad++; $display("FAIL empty_wr_q got=%h exp=a5a5a5a5", q); end
      total++; if (count !== 3'd1)     begin bad++; $display("FAIL empty_wr_count got=%0d exp=1", count); end
      total++; if (q_valid !== 1'b1)   begin bad++; $display("FAIL empty_wr_valid got=%b exp=1", q_valid); end
      flush = 1'b1;
      cyc();
      idle();
      total++; if (ovf !== 1'b0)    begin bad++; $display("FAIL flush_ovf got=%b exp=0", ovf); end
      total++; if (udf !== 1'b0)    begin bad++; $display("FAIL flush_udf got=%b exp=0", udf); end
      total++; if (count !== 3'd0)  begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
   endtask

   task automatic test_back_to_back();
      push(32'h100); push(32'h101);
      for (int i = 0; i < 10; i++) begin
         en = 1'b1; rd_en = 1'b1; d = 32'h102 + 32'(i);
         total++; if (q !== 32'h100 + 32'(i)) begin bad++; $display("FAIL wrap_q[%0d] got=%h exp=%h", i, q, 32'h100 + 32'(i)); end
         cyc();
         total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, count); end
      end
      idle();
      total++; if (ovf !== 1'b0 || udf !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b%b exp=00", ovf, udf); end
      total++; if (q !== 32'h10A) begin bad++; $display("FAIL wrap_head got=%h exp=10a", q); end
   endtask

   task automatic test_flush_reset();
      push(32'h200); push(32'h201); push(32'h202);
      rd_en = 1'b1;
      cyc();
      idle();
      total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_flush_count got=%0d exp=3", count); end
      total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL pre_flush_ovf got=%b exp=1", ovf); end
      flush = 1'b1; en = 1'b1; d = 32'h300;
      cyc();
      idle();
      total++; if (count !== 3'd0)   begin bad++; $display("FAIL flush_mid_count got=%0d exp=0", count); end
      total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL flush_mid_ovf got=%b exp=0", ovf); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL flush_wr_ignored got=%b exp=0", q_valid); end
      push(32'h400); push(32'h401);
      total++; if (count !== 3'd2) begin bad++; $display("FAIL refill_count got=%0d exp=2", count); end
      total++; if (q !== 32'h400)  begin bad++; $display("FAIL refill_q got=%h exp=400", q); end
      #2 clr_n = 1'b0;
      #1;
      total++; if (count !== 3'd0)   begin bad++; $display("FAIL async_count got=%0d exp=0", count); end
      total++; if (q !== 32'h0)      begin bad++; $display("FAIL async_q got=%h exp=0", q); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", q_valid); end
      cyc();
      clr_n = 1'b1;
      cyc();
      total++; if (count !== 3'd0)   begin bad++; $display("FAIL post_reset_count got=%0d exp=0", count); end
   endtask

   initial begin
      clr_n = 1'b1;
      idle();
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_empty();
      test_back_to_back();
      test_flush_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_result_fifo.md
# wb_result_fifo

Reader side for values produced by the processor's enable-written 32-bit registers. A producer issues one-cycle write strobes (`d`/`en`, the same semantics as a register write), and this block queues each value in order. A consumer pops the values with a `rd_en` strobe. The block sits between multi-cycle result producers (multdiv, load return) and the writeback stage, so no result is lost when writeback is busy.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 4: number of entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `clr_n`, input, 1: asynchronous active-low reset. Clears all state immediately.
- `d`, input, WIDTH: write data.
- `en`, input, 1: write strobe. One entry per cycle in which it is high.
- `flush`, input, 1: synchronous clear (pipeline squash).
- `rd_en`, input, 1: pop strobe from the consumer.
- `q`, output, WIDTH: head entry when `q_valid`=1, all zeros otherwise.
- `q_valid`, output, 1: queue non-empty.
- `full`, output, 1: count == DEPTH.
- `count`, output, log2(DEPTH)+1: number of occupied entries (0..DEPTH).
- `ovf`, output, 1: sticky flag, set when a write is dropped.
- `udf`, output, 1: sticky flag, set when a pop is requested while empty.

## Operation
- Storage is a circular array of DEPTH words, with a write pointer and a read pointer of log2(DEPTH) bits each.
  - Both pointers wrap modulo DEPTH.
  - `count` is held in a separate register.
- Accepted write (`wr_ok`): `en` && (!`full` || `rd_en`).
  - Action: `mem[wptr]` ← `d`, then `wptr` increments.
- Accepted pop (`rd_ok`): `rd_en` && `q_valid`.
  - Action: `rptr` increments.
  - The popped word is the value on `q` during that cycle.
- `count` next value: +1 on write only, −1 on pop only, unchanged on both or neither.
- Full with `en` and `rd_en` together: pop and write both happen, `count` stays DEPTH, no overflow.
- Full with `en` and no `rd_en`: `d` is discarded, storage is unchanged, `ovf` is set to 1.
- Empty with `rd_en`: no state change except `udf` is set to 1.
  - If `en` is also high, the write is still accepted.
- Priority at each edge: `flush` > write/pop.
  - `flush`=1 sets the pointers, `count`, `ovf` and `udf` to 0.
  - `en` and `rd_en` are ignored in that cycle.
  - Storage contents are not cleared.
- `ovf` and `udf` clear only on `flush` or reset.
- Reset (`clr_n`=0, asynchronous, with no dependence on `clk`):
  - pointers, `count`, `ovf`, `udf` = 0;
  - all storage words = 0;
  - outputs read `q`=0, `q_valid`=0, `full`=0, `count`=0, `ovf`=0, `udf`=0.
- Deassertion of `clr_n` takes effect at the next rising edge. A mid-operation reset drops all queued entries.

## Timing
- `q`, `q_valid`, `full` and `count` are decoded from registers only. There is no combinational path from `d`/`en`/`rd_en` to any output.
- Write latency: a value written at edge N appears on `q` (if it is the head) and is counted in `q_valid`/`count` from just after edge N. There is no same-cycle fall-through while empty.
- Pop: with `rd_en`=1 in cycle N, the next entry (or `q`=0 and `q_valid`=0 if the queue was emptied) is presented after edge N.
- Throughput: one write and one pop per cycle, sustained in any occupancy state.
- `ovf` and `udf` assert on the edge that ends the offending cycle.

## Test plan
- Reset then fill:
  - Stimulus: `clr_n` low for 2 cycles, release; write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: `count` steps 1→4; `full`=1 after the 4th edge; `q`=0x11 throughout.
- Drain order:
  - Stimulus: from the full state, `rd_en`=1 for 4 cycles.
  - Required: `q` shows 0x11, 0x22, 0x33, 0x44 in turn; then `q_valid`=0, `q`=0, `count`=0, `udf`=0.
- Overflow and simultaneous access at full:
  - Stimulus: from full, write 0x55 with `rd_en`=0.
  - Required: `ovf`=1; contents unchanged.
  - Stimulus: then write 0x66 with `rd_en`=1.
  - Required: 0x11 is popped; `count` stays 4; the tail becomes 0x66.
- Empty corner:
  - Stimulus: while empty, assert `rd_en` alone.
  - Required: `udf`=1, `count`=0.
  - Stimulus: then assert `en` (`d`=0xA5A5A5A5) together with `rd_en`.
  - Required: write accepted; `q`=0xA5A5A5A5, `count`=1 next cycle.
- Wrap-around:
  - Stimulus: 10 cycles of simultaneous write/pop at `count`=2, with `d` incrementing from 0x100.
  - Required: output order exactly matches input order; `count` stays 2; no flags set.
- Flush and async reset mid-operation:
  - Stimulus: at `count`=3 with `ovf`=1, assert `flush` together with `en`.
  - Required: `count`=0, `ovf`=0, write ignored.
  - Stimulus: refill to 2 entries, then drop `clr_n` between clock edges.
  - Required: outputs go to zero immediately, without waiting for a clock edge.
